// File: rtl/dmem_access_ctrl_if.sv
// Data-memory access bundle: MEM-stage load/store controls, pipeline
// stall/result returns and the req/ack data-memory port.
//   slave : dmem_access_ctrl side (consumes controls, drives dmem_*)
//   master: pipeline + memory side (drives controls, ack and rdata)
interface dmem_access_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  inst_size;
    logic        is_signed;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        timeout;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport slave (
        input  mem_read, mem_write, inst_size, is_signed,
        input  addr, store_data, dmem_ack, dmem_rdata,
        output stall, load_data, load_valid, misalign, timeout,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );

    modport master (
        output mem_read, mem_write, inst_size, is_signed,
        output addr, store_data, dmem_ack, dmem_rdata,
        input  stall, load_data, load_valid, misalign, timeout,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: IDLE -> REQ (until ack/timeout) -> DONE.
// Ports: clk, reset (sync, active-high), bus (dmem_access_ctrl_if.slave).
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input logic               clk,
    input logic               reset,
    dmem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TO_EN  = (TIMEOUT_CYCLES != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             req_q, we_q;
    logic [31:0]      addr_q, wdata_q, ldata_q;
    logic [3:0]       be_q;
    logic [1:0]       off_q;
    logic             byte_q, half_q, sign_q;
    logic             lv_q, mis_q, to_q;

    logic             access, is_byte, is_half, is_word;
    logic             misaligned, accept, expire, stall;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c, shifted, ext;

    always_comb begin
        is_byte    = (bus.inst_size == 2'b10);
        is_half    = (bus.inst_size == 2'b01);
        is_word    = !is_byte && !is_half;
        access     = bus.mem_read | bus.mem_write;
        misaligned = (is_half && bus.addr[0]) ||
                     (is_word && (bus.addr[1:0] != 2'b00));
        accept     = (state_q == IDLE) && access && !misaligned;
        cnt_inc    = cnt_q + CNT_W'(1);
        expire     = TO_EN && (cnt_inc == TO_LIM);
    end

    // Store lane placement
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = bus.store_data;
        unique case (1'b1)
            is_byte: begin
                be_c    = 4'b0001 << bus.addr[1:0];
                wdata_c = {4{bus.store_data[7:0]}};
            end
            is_half: begin
                be_c    = 4'b0011 << {bus.addr[1], 1'b0};
                wdata_c = {2{bus.store_data[15:0]}};
            end
            is_word: begin
                be_c    = 4'b1111;
                wdata_c = bus.store_data;
            end
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        shifted = bus.dmem_rdata >> {off_q, 3'b000};
        ext     = shifted;
        unique case (1'b1)
            byte_q:  ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            half_q:  ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    stall   = 1'b1;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus.dmem_ack || expire) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reset) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ldata_q <= '0;
            off_q   <= '0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            sign_q  <= 1'b0;
            lv_q    <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lv_q    <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q   <= 1'b1;
                        we_q    <= bus.mem_write;
                        addr_q  <= {bus.addr[31:2], 2'b00};
                        be_q    <= be_c;
                        wdata_q <= wdata_c;
                        off_q   <= bus.addr[1:0];
                        byte_q  <= is_byte;
                        half_q  <= is_half;
                        sign_q  <= bus.is_signed;
                        cnt_q   <= '0;
                    end else if (access) begin
                        mis_q <= 1'b1;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_inc;
                    if (bus.dmem_ack) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        be_q  <= '0;
                        if (!we_q) begin
                            lv_q    <= 1'b1;
                            ldata_q <= ext;
                        end
                    end else if (expire) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= '0;
                        to_q    <= 1'b1;
                        ldata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall      = stall;
    assign bus.load_data  = ldata_q;
    assign bus.load_valid = lv_q;
    assign bus.misalign   = mis_q;
    assign bus.timeout    = to_q;
    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_be    = be_q;
    assign bus.dmem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, reset-in-REQ
// sequence and randomized accesses against a behavioural model.
module tb_dmem_access_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] sd;
        int          ackw;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        logic        to;
    } vec_t;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    logic        mis_pend = 1'b0;
    logic [31:0] last_ld  = 32'h0;
    vec_t        tbl[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_flags(input logic e_stall, input logic e_req,
                             input logic e_lv, input logic e_to);
        chk1("stall", bus.stall, e_stall);
        chk1("dmem_req", bus.dmem_req, e_req);
        chk1("load_valid", bus.load_valid, e_lv);
        chk1("timeout", bus.timeout, e_to);
        chk1("misalign", bus.misalign, mis_pend);
        mis_pend = 1'b0;
    endtask

    task automatic clear_ctl();
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.inst_size  = 2'b00;
        bus.is_signed  = 1'b0;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;
    endtask

    function automatic vec_t mk(input logic rd, input logic wr,
                                input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] sd,
                                input int ackw, input logic [31:0] rdata,
                                input logic mis, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] ld,
                                input logic to);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.sg = sg;
        v.a = a; v.sd = sd; v.ackw = ackw; v.rdata = rdata;
        v.mis = mis; v.be = be; v.wd = wd; v.ld = ld; v.to = to;
        return v;
    endfunction

    // Behavioural reference: access width in bytes, alignment by modulo,
    // lane data by arithmetic shift/mask and two's-complement wrap.
    function automatic vec_t model(input logic rd, input logic wr,
                                   input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] sd,
                                   input int ackw, input logic [31:0] rdata);
        vec_t        v;
        int          nb;
        int          off;
        logic [31:0] val;
        logic [31:0] span;
        nb  = (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
        off = int'(a[1:0]);
        v = mk(rd, wr, sz, sg, a, sd, ackw, rdata, 1'b0, 4'h0, 32'h0,
               32'h0, 1'b0);
        v.mis = (int'(a[1:0]) % nb) != 0;
        v.be  = 4'(((1 << nb) - 1) << off);
        if (nb == 1) v.wd = {24'h0, sd[7:0]} * 32'h0101_0101;
        else if (nb == 2) v.wd = {16'h0, sd[15:0]} * 32'h0001_0001;
        else v.wd = sd;
        val = rdata >> (8 * off);
        if (nb < 4) begin
            span = 32'd1 << (8 * nb);
            val  = val % span;
            if (sg && (val >= (span >> 1))) val = val - span;
        end
        v.to = (ackw >= TO);
        v.ld = v.to ? 32'h0 : val;
        return v;
    endfunction

    task automatic do_access(input vec_t v, input int tag);
        logic        acked;
        logic [31:0] eld;
        @(negedge clk);
        bus.mem_read   = v.rd;
        bus.mem_write  = v.wr;
        bus.inst_size  = v.sz;
        bus.is_signed  = v.sg;
        bus.addr       = v.a;
        bus.store_data = v.sd;
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
        #1;
        if (v.mis) begin
            chk_flags(1'b0, 1'b0, 1'b0, 1'b0);
            mis_pend = 1'b1;
            return;
        end
        chk_flags(1'b1, 1'b0, 1'b0, 1'b0);
        acked = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            bus.dmem_ack   = (k == v.ackw);
            bus.dmem_rdata = (k == v.ackw) ? v.rdata : $urandom;
            #1;
            chk_flags(1'b1, 1'b1, 1'b0, 1'b0);
            chk1("dmem_we", bus.dmem_we, v.wr);
            chk("dmem_addr", bus.dmem_addr, {v.a[31:2], 2'b00});
            chk("dmem_be", 32'(bus.dmem_be), 32'(v.be));
            chk("dmem_wdata", bus.dmem_wdata, v.wd);
            if (k == v.ackw) begin
                acked = 1'b1;
                break;
            end
        end
        // DONE: a late ack here must be ignored
        @(negedge clk);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = $urandom;
        #1;
        eld     = v.to ? 32'h0 : (v.wr ? last_ld : v.ld);
        last_ld = eld;
        chk_flags(1'b0, 1'b0, !v.to && !v.wr, v.to);
        chk1("acked", acked, !v.to);
        chk("done_be", 32'(bus.dmem_be), 32'h0);
        chk1("done_we", bus.dmem_we, 1'b0);
        chk("load_data", bus.load_data, eld);
        if (n_bad > 0 && tag >= 0 && tag < 13)
            ;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        clear_ctl();
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
        #1;
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t        v;
        logic        rd, wr;
        logic [1:0]  sz;
        logic [31:0] a;

        tbl[0]  = mk(1, 0, 2'b00, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF,
                     0, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
        tbl[1]  = mk(1, 0, 2'b10, 1, 32'h103, 32'h0, 0, 32'h80112233,
                     0, 4'b1000, 32'h0, 32'hFFFFFF80, 0);
        tbl[2]  = mk(1, 0, 2'b10, 0, 32'h103, 32'h0, 0, 32'h80112233,
                     0, 4'b1000, 32'h0, 32'h00000080, 0);
        tbl[3]  = mk(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 3, 32'h0,
                     0, 4'b1100, 32'hABCDABCD, 32'h0, 0);
        tbl[4]  = mk(1, 0, 2'b00, 0, 32'h101, 32'h0, 0, 32'h0,
                     1, 4'b0000, 32'h0, 32'h0, 0);
        tbl[5]  = mk(1, 0, 2'b00, 0, 32'h104, 32'h0, 1, 32'h01234567,
                     0, 4'b1111, 32'h0, 32'h01234567, 0);
        tbl[6]  = mk(1, 0, 2'b00, 0, 32'h108, 32'h0, 99, 32'h0,
                     0, 4'b1111, 32'h0, 32'h0, 1);
        tbl[7]  = mk(1, 0, 2'b01, 1, 32'h10A, 32'h0, 0, 32'h80017FFF,
                     0, 4'b1100, 32'h0, 32'hFFFF8001, 0);
        tbl[8]  = mk(0, 1, 2'b10, 0, 32'h301, 32'h000000A5, 2, 32'h0,
                     0, 4'b0010, 32'hA5A5A5A5, 32'h0, 0);
        tbl[9]  = mk(0, 1, 2'b01, 0, 32'h203, 32'h0, 0, 32'h0,
                     1, 4'b0000, 32'h0, 32'h0, 0);
        tbl[10] = mk(1, 0, 2'b01, 0, 32'h100, 32'h0, 0, 32'h1234F00D,
                     0, 4'b0011, 32'h0, 32'h0000F00D, 0);
        tbl[11] = mk(0, 1, 2'b11, 0, 32'h10C, 32'hCAFEBABE, 2, 32'h0,
                     0, 4'b1111, 32'hCAFEBABE, 32'h0, 0);
        tbl[12] = mk(1, 1, 2'b10, 0, 32'h302, 32'h0000007E, 0, 32'h0,
                     0, 4'b0100, 32'h7E7E7E7E, 32'h0, 0);

        reset          = 1'b1;
        clear_ctl();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        @(negedge clk);
        bus.mem_read = 1'b1;
        bus.addr     = 32'h100;
        #1;
        chk1("stall_in_reset", bus.stall, 1'b0);
        chk("rst_load_data", bus.load_data, 32'h0);
        chk("rst_dmem_addr", bus.dmem_addr, 32'h0);
        chk("rst_dmem_wdata", bus.dmem_wdata, 32'h0);
        chk("rst_dmem_be", 32'(bus.dmem_be), 32'h0);
        chk1("rst_dmem_we", bus.dmem_we, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        clear_ctl();

        for (int i = 0; i < 13; i++) do_access(tbl[i], i);
        idle_cycle();

        // Reset during the 2nd REQ cycle
        @(negedge clk);
        bus.mem_read  = 1'b1;
        bus.inst_size = 2'b00;
        bus.addr      = 32'h400;
        bus.dmem_ack  = 1'b0;
        #1;
        chk1("rr_accept_stall", bus.stall, 1'b1);
        @(negedge clk);
        #1;
        chk1("rr_req1", bus.dmem_req, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("rr_req2", bus.dmem_req, 1'b1);
        chk1("rr_stall_reset", bus.stall, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        clear_ctl();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h55AA55AA;
        #1;
        chk1("rr_req_cleared", bus.dmem_req, 1'b0);
        chk("rr_be", 32'(bus.dmem_be), 32'h0);
        chk("rr_addr", bus.dmem_addr, 32'h0);
        chk1("rr_stall", bus.stall, 1'b0);
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        #1;
        chk1("rr_no_load_valid", bus.load_valid, 1'b0);
        chk("rr_load_data", bus.load_data, 32'h0);
        chk1("rr_idle_stall", bus.stall, 1'b0);
        last_ld = 32'h0;

        for (int i = 0; i < 300; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            v  = model(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom,
                       int'($urandom_range(0, TO + 1)), $urandom);
            do_access(v, -1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Multi-cycle data-memory access sequencer for the 32I core's MEM stage. It consumes the decoder's load/store controls (mem_read, mem_write, inst_size, is_signed) together with the ALU address and store data. It drives a req/ack data-memory port with byte enables and lane-replicated write data, and returns the sign/zero-extended load result. It stalls the pipeline until the access completes, and flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 255, REQ-state cycles without ack before abort; 0 disables the timeout.
CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
mem_read  in  1  load request from decode, active-high
mem_write  in  1  store request from decode, active-high; wins if both are high
inst_size  in  2  00 word, 01 half, 10 byte; 11 treated as word
is_signed  in  1  1: sign-extend loads; 0: zero-extend
addr  in  32  byte address (ALU result)
store_data  in  32  rs2 value
stall  out  1  hold the pipeline this cycle (combinational)
load_data  out  32  extended load result
load_valid  out  1  1-cycle pulse; load_data is valid
misalign  out  1  1-cycle pulse; access rejected
timeout  out  1  1-cycle pulse; access aborted
dmem_req  out  1  request; held until ack
dmem_we  out  1  1 write, 0 read
dmem_addr  out  32  {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  completion, sampled only in REQ
dmem_rdata  in  32  read word, valid with ack

Behaviour:
- Reset (sync, high): state = IDLE; all registered outputs = 0; timeout counter = 0. stall = 0 while reset is high.
- FSM states: IDLE, REQ, DONE.
- IDLE, access present (mem_read|mem_write) and aligned:
  - stall = 1.
  - Register dmem_addr, dmem_we, dmem_be, dmem_wdata, addr[1:0], size and sign.
  - Next state REQ, with dmem_req = 1.
- IDLE, misaligned access (half with addr[0]=1; word with addr[1:0]≠0):
  - No request; stay in IDLE.
  - misalign = 1 for the next cycle only; stall = 0.
- REQ:
  - stall = 1; dmem_* outputs held stable; counter increments each cycle.
  - On dmem_ack = 1: capture dmem_rdata, clear dmem_req/dmem_we/dmem_be, next state DONE.
  - If the counter reaches TIMEOUT_CYCLES (nonzero) without ack: same clears, next state DONE with the abort flag set.
- DONE (exactly 1 cycle):
  - stall = 0; the pipeline advances at the end of this cycle; next state IDLE.
  - The still-present controls are not re-accepted in DONE.
  - Normal load: load_valid = 1.
  - Store: load_valid = 0.
  - Aborted access: timeout = 1, load_valid = 0, load_data = 0.
- Latency: with ack in the first REQ cycle, stall is high for 2 cycles and the instruction completes on the 3rd. Each extra wait cycle adds 1.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Write data:
  - byte: {4{store_data[7:0]}}
  - half: {2{store_data[15:0]}}
  - word: store_data
- Load extract: rdata >> (8*addr[1:0]), then extend bit 7 (byte) or bit 15 (half) when is_signed=1, else zero-extend. Word loads pass through.
- load_data holds its value until the next load completes or reset.
- dmem_ack outside REQ (late/spurious) is ignored and has no effect.
- Reset in REQ: dmem_req = 0 from the next cycle; a subsequent ack is ignored.
- The counter clears on entry to REQ.

Test Plan:
- lw addr=0x100, ack in the 1st REQ cycle, rdata=0xDEADBEEF -> stall high for 2 cycles; dmem_addr=0x100, be=1111, we=0; DONE: load_valid=1, load_data=0xDEADBEEF.
- lb signed addr=0x103, rdata=0x80112233 -> be=1000, load_data=0xFFFFFF80; same with lbu (is_signed=0) -> 0x00000080.
- sh addr=0x202, store_data=0x1234ABCD, ack after 3 wait cycles -> dmem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1; stall high for 5 cycles; load_valid=0.
- lw addr=0x101 -> no dmem_req; misalign pulse for 1 cycle; stall=0; next instruction accepted the following cycle.
- TIMEOUT_CYCLES=4, ack never arrives -> dmem_req drops after 4 REQ cycles; timeout=1, load_valid=0; a late ack is ignored and the FSM returns to IDLE.
- reset asserted in the 2nd REQ cycle -> next cycle all outputs 0 and state IDLE; an ack in the following cycle produces no load_valid.
